// File: rtl/instruction_fetch.sv
// Fetch stage: issues word-aligned instruction requests, tracks them in an in-order
// buffer, and hands instructions with their PC to decode; redirects drop stale responses.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pc_write_o,
  input  logic                  flush_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_resp_data_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [DATA_WIDTH-1:0] id_pc_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled;
  logic [PTR_W-1:0]      wr_ptr, fill_ptr, rd_ptr;
  logic [CNT_W-1:0]      occ, drop, unfilled;
  logic                  accept, pop, resp_keep, resp_drop;

  function automatic logic [CNT_W-1:0] count_ones(input logic [FIFO_DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Requests stay blocked while stale responses are still owed, so they never alias new entries.
  assign imem_req_valid_o = rst_n && !flush_i && (occ < CNT_W'(FIFO_DEPTH)) && (drop == '0);
  assign imem_addr_o      = {pc_i[DATA_WIDTH-1:2], 2'b00};
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  assign pc_write_o       = accept;

  assign resp_keep = imem_resp_valid_i && (drop == '0);
  assign resp_drop = imem_resp_valid_i && (drop != '0);
  assign unfilled  = occ - count_ones(filled);

  assign id_valid_o = !flush_i && (occ != '0) && filled[rd_ptr];
  assign id_instr_o = instr_q[rd_ptr];
  assign id_pc_o    = pc_q[rd_ptr];
  assign pop        = id_valid_o && id_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop     <= '0;
      filled   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Every allocated-but-unfilled entry still has a response on its way.
      drop     <= drop - CNT_W'(resp_drop) + unfilled - CNT_W'(resp_keep);
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      filled   <= '0;
    end else begin
      if (accept) begin
        pc_q[wr_ptr]   <= pc_i;
        filled[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        filled[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (resp_keep) begin
        instr_q[fill_ptr] <= imem_resp_data_i;
        filled[fill_ptr]  <= 1'b1;
        fill_ptr          <= fill_ptr + 1'b1;
      end
      if (resp_drop) drop <= drop - 1'b1;
      occ <= occ + CNT_W'(accept) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small in-order memory model answers requests,
// and each task checks one scenario cycle by cycle.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_write;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks = 0;
  int errors = 0;

  // In-order memory model: responses become visible the cycle after acceptance.
  logic        mem_en;
  logic [31:0] q_data [64];
  logic [5:0]  q_head, q_tail;
  int          q_cnt;

  assign resp_valid = mem_en && (q_cnt != 0);
  assign resp_data  = q_data[q_head];

  always #5 clk = ~clk;

  instruction_fetch #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_write_o(pc_write), .flush_i(flush),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
    .imem_resp_valid_i(resp_valid), .imem_resp_data_i(resp_data),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_instr_o(id_instr), .id_pc_o(id_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic step();
    logic acc, rsp;
    logic [31:0] a;
    acc = req_valid && req_ready;
    rsp = resp_valid;
    a   = addr;
    @(posedge clk); #1;
    if (rsp) begin q_head = q_head + 1'b1; q_cnt--; end
    if (acc) begin
      q_data[q_tail] = instr_of(a);
      q_tail = q_tail + 1'b1;
      q_cnt++;
      pc = pc + 32'd4;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; req_ready = 1'b1; mem_en = 1'b1; id_ready = 1'b1; pc = 32'h0;
    q_head = '0; q_tail = '0; q_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b1; req_ready = 1'b1; mem_en = 1'b0; id_ready = 1'b1; pc = 32'h0;
    q_head = '0; q_tail = '0; q_cnt = 0;
    @(posedge clk); #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0h exp 0", req_valid); end
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got %0h exp 0", pc_write); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0h exp 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h exp 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    checks++; if (req_valid !== 1'b1 || addr !== 32'h0 || pc_write !== 1'b1) begin errors++; $display("FAIL stream_c0_req got v=%0h a=%h w=%0h exp 1/0/1", req_valid, addr, pc_write); end
    step();
    checks++; if (req_valid !== 1'b1 || addr !== 32'h4 || id_valid !== 1'b0) begin errors++; $display("FAIL stream_c1 got v=%0h a=%h idv=%0h exp 1/4/0", req_valid, addr, id_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin errors++; $display("FAIL stream_c2_id got v=%0h pc=%h i=%h exp 1/0/%h", id_valid, id_pc, id_instr, instr_of(32'h0)); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stream_c2_full got %0h exp 0", req_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== instr_of(32'h4)) begin errors++; $display("FAIL stream_c3_id got v=%0h pc=%h i=%h exp 1/4/%h", id_valid, id_pc, id_instr, instr_of(32'h4)); end
    checks++; if (req_valid !== 1'b1 || addr !== 32'h8) begin errors++; $display("FAIL stream_c3_req got v=%0h a=%h exp 1/8", req_valid, addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready = 1'b0;
    step(); step();
    checks++; if (req_valid !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL bp_full_c2 got v=%0h w=%0h exp 0/0", req_valid, pc_write); end
    step();
    checks++; if (req_valid !== 1'b0 || pc_write !== 1'b0 || pc !== 32'h8) begin errors++; $display("FAIL bp_full_c3 got v=%0h w=%0h pc=%h exp 0/0/8", req_valid, pc_write, pc); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v=%0h pc=%h exp 1/0", id_valid, id_pc); end
    id_ready = 1'b1; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_req got %0h exp 0", req_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== instr_of(32'h4)) begin errors++; $display("FAIL bp_second got v=%0h pc=%h i=%h exp 1/4/%h", id_valid, id_pc, id_instr, instr_of(32'h4)); end
    checks++; if (req_valid !== 1'b1 || addr !== 32'h8 || pc_write !== 1'b1) begin errors++; $display("FAIL bp_reissue got v=%0h a=%h w=%0h exp 1/8/1", req_valid, addr, pc_write); end
  endtask

  task automatic test_req_stall();
    do_reset();
    req_ready = 1'b0; pc = 32'h43; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_valid !== 1'b1 || addr !== 32'h40 || pc_write !== 1'b0) begin errors++; $display("FAIL stall_%0d got v=%0h a=%h w=%0h exp 1/40/0", i, req_valid, addr, pc_write); end
      step();
    end
    req_ready = 1'b1; #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL stall_release got %0h exp 1", pc_write); end
    step();
    checks++; if (req_valid !== 1'b1 || addr !== 32'h44) begin errors++; $display("FAIL stall_next got v=%0h a=%h exp 1/44", req_valid, addr); end
  endtask

  task automatic test_flush();
    do_reset();
    pc = 32'h10; id_ready = 1'b0; mem_en = 1'b0;
    step(); step();
    flush = 1'b1; pc = 32'h100; #1;
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle got v=%0h idv=%0h exp 0/0", req_valid, id_valid); end
    step();
    flush = 1'b0; mem_en = 1'b1; id_ready = 1'b1; #1;
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop2 got v=%0h idv=%0h exp 0/0", req_valid, id_valid); end
    step();
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop1 got v=%0h idv=%0h exp 0/0", req_valid, id_valid); end
    step();
    checks++; if (req_valid !== 1'b1 || addr !== 32'h100 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_resume got v=%0h a=%h idv=%0h exp 1/100/0", req_valid, addr, id_valid); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_wait got %0h exp 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin errors++; $display("FAIL flush_first got v=%0h pc=%h i=%h exp 1/100/%h", id_valid, id_pc, id_instr, instr_of(32'h100)); end
  endtask

  task automatic test_flush_with_resp();
    do_reset();
    pc = 32'h20; id_ready = 1'b0; mem_en = 1'b0;
    step(); step();
    mem_en = 1'b1; flush = 1'b1; pc = 32'h200; #1;
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL fr_cycle got v=%0h idv=%0h exp 0/0", req_valid, id_valid); end
    step();
    flush = 1'b0; id_ready = 1'b1; #1;
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL fr_drop1 got v=%0h idv=%0h exp 0/0", req_valid, id_valid); end
    step();
    checks++; if (req_valid !== 1'b1 || addr !== 32'h200 || id_valid !== 1'b0) begin errors++; $display("FAIL fr_resume got v=%0h a=%h idv=%0h exp 1/200/0", req_valid, addr, id_valid); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fr_wait got %0h exp 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== instr_of(32'h200)) begin errors++; $display("FAIL fr_first got v=%0h pc=%h i=%h exp 1/200/%h", id_valid, id_pc, id_instr, instr_of(32'h200)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    id_ready = 1'b0;
    step(); step(); step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %0h exp 1", id_valid); end
    #2 rst_n = 1'b0;
    q_head = '0; q_tail = '0; q_cnt = 0;
    #1;
    checks++; if (req_valid !== 1'b0 || pc_write !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL ar_ctrl got v=%0h w=%0h idv=%0h exp 0/0/0", req_valid, pc_write, id_valid); end
    checks++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL ar_data got i=%h pc=%h exp 0/0", id_instr, id_pc); end
    @(posedge clk); #1;
    rst_n = 1'b1; pc = 32'h80; id_ready = 1'b1; #1;
    checks++; if (req_valid !== 1'b1 || addr !== 32'h80) begin errors++; $display("FAIL ar_restart got v=%0h a=%h exp 1/80", req_valid, addr); end
    step(); step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_instr !== instr_of(32'h80)) begin errors++; $display("FAIL ar_first got v=%0h pc=%h i=%h exp 1/80/%h", id_valid, id_pc, id_instr, instr_of(32'h80)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_flush();
    test_flush_with_resp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
